// File: rtl/pnser_arb_if.sv
// pnser_arb_if: requester/serializer bus of the pnser_arb scheduler.
//   req_i     : per-requester request, held while a word is pending
//   rnd_i     : per-requester 32-bit word, slice k = [32k+31:32k]
//   rnd_len_i : per-requester 5-bit length, slice k = [5k+4:5k]
//   ack_o     : per-requester one-cycle consume pulse
//   gnt_o     : registered one-hot grant
//   busy_o    : a grant is being served
//   ser_dat_o, ser_len_o, ser_vld_o : word presented to the serializer
//   ser_ack_i : serializer latched the presented word
// Modports: slave = arbiter side, master = generator bank / serializer side.
`timescale 1ns/1ps
interface pnser_arb_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned DAT_W = 32;
    localparam int unsigned LEN_W = 5;

    logic [NREQ-1:0]       req_i;
    logic [NREQ*DAT_W-1:0] rnd_i;
    logic [NREQ*LEN_W-1:0] rnd_len_i;
    logic [NREQ-1:0]       ack_o;
    logic [NREQ-1:0]       gnt_o;
    logic                  busy_o;
    logic [DAT_W-1:0]      ser_dat_o;
    logic [LEN_W-1:0]      ser_len_o;
    logic                  ser_vld_o;
    logic                  ser_ack_i;

    modport slave (
        input  req_i, rnd_i, rnd_len_i, ser_ack_i,
        output ack_o, gnt_o, busy_o, ser_dat_o, ser_len_o, ser_vld_o
    );

    modport master (
        output req_i, rnd_i, rnd_len_i, ser_ack_i,
        input  ack_o, gnt_o, busy_o, ser_dat_o, ser_len_o, ser_vld_o
    );
endinterface

// File: rtl/pnser_arb.sv
// pnser_arb: round-robin scheduler sharing one serializer among NREQ
// random-number sources. One requester is granted at a time for at most
// BURST words; its word/length are muxed to the serializer and the
// serializer ack is routed back to it alone.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : pnser_arb_if.slave (requests, data, acks, grant, serializer side)
// Optional feature macro: PNSER_ARB_FIXPRI_EN -- requester 0 wins every
// arbitration it requests in without advancing the round-robin pointer.
`timescale 1ns/1ps
module pnser_arb #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned BURST    = 4,
    parameter logic [31:0] IDLE_DAT = 32'h0,
    parameter logic [4:0]  IDLE_LEN = 5'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    pnser_arb_if.slave  bus
);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned LEN_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_REL   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [PTR_W-1:0]  r_sel;
    logic [PTR_W-1:0]  w_sel_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [NREQ-1:0]   w_req_rr;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  w_win;
    logic              w_win_vld;
    logic              w_ptr_adv;
    logic              w_req_sel;

    logic [DAT_W-1:0]  w_rnd [NREQ];
    logic [LEN_W-1:0]  w_len [NREQ];

    // Unpack the flat requester buses into per-requester slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_rnd[g] = bus.rnd_i[DAT_W*g +: DAT_W];
        assign w_len[g] = bus.rnd_len_i[LEN_W*g +: LEN_W];
    end

    // Winner search: first request at or above the pointer, with wrap.
    always_comb begin
        w_req_rr  = bus.req_i;
        w_win     = '0;
        w_win_vld = 1'b0;
        w_ptr_adv = 1'b1;
        w_idx     = '0;
`ifdef PNSER_ARB_FIXPRI_EN
        // Requester 0 is served outside the rotation.
        w_req_rr[0] = 1'b0;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = PTR_W'((32'(r_ptr) + i) % NREQ);
            if (!w_win_vld && w_req_rr[w_idx]) begin
                w_win_vld = 1'b1;
                w_win     = w_idx;
            end
        end
`ifdef PNSER_ARB_FIXPRI_EN
        if (bus.req_i[0]) begin
            w_win_vld = 1'b1;
            w_win     = '0;
            w_ptr_adv = 1'b0;
        end
`endif
    end

    assign w_req_sel = bus.req_i[r_sel];

    // State, grant, pointer and burst-count registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = '0;
                    if (w_ptr_adv) begin
                        w_ptr_nxt = PTR_W'((32'(w_win) + 32'd1) % NREQ);
                    end
                end
            end
            ST_GRANT: begin
                if (bus.ser_ack_i) begin
                    // Burst limit reached: force a rearbitration point.
                    if (r_cnt == CNT_W'(BURST - 1)) begin
                        w_state_nxt = ST_REL;
                        w_gnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (!w_req_sel) begin
                    // Requester withdrew with nothing in flight.
                    w_state_nxt = ST_REL;
                    w_gnt_nxt   = '0;
                end
            end
            ST_REL: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // Serializer-side mux and ack routing; acks outside GRANT are dropped.
    always_comb begin
        bus.ser_dat_o = IDLE_DAT;
        bus.ser_len_o = IDLE_LEN;
        bus.ser_vld_o = 1'b0;
        bus.ack_o     = '0;
        if (r_state == ST_GRANT) begin
            bus.ser_dat_o = w_rnd[r_sel];
            bus.ser_len_o = w_len[r_sel];
            bus.ser_vld_o = w_req_sel;
            if (bus.ser_ack_i) begin
                bus.ack_o = r_gnt;
            end
        end
    end

    assign bus.gnt_o  = r_gnt;
    assign bus.busy_o = (r_state == ST_GRANT);

endmodule

// File: doc/pnser_arb.md
Name: pnser_arb

Overview:
- Round-robin scheduler that shares one serializer among NREQ random-number sources.
- Grants one requester at a time and muxes its 32-bit word and 5-bit length onto the serializer's data inputs.
- Routes the serializer's per-word ack pulse back to the granted requester only.
- Holds a grant for at most BURST words so every source gets serial bandwidth. Sits between the generator bank and the serializer.

Parameters:
- NREQ, 4: number of requesters, 2..8; pointer width is clog2(NREQ).
- BURST, 4: maximum words served per grant, 1..15.
- IDLE_DAT, 32'h0: word driven on ser_dat_o when no grant is active.
- IDLE_LEN, 5'd0: length driven on ser_len_o when no grant is active.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low. 0 clears all state immediately.
- req_i  in  NREQ  per-requester request. Held high while the requester has a word pending.
- rnd_i  in  NREQ*32  per-requester data; slice k is bits [32k+31:32k].
- rnd_len_i  in  NREQ*5  per-requester length; slice k is bits [5k+4:5k].
- ack_o  out  NREQ  one-cycle pulse; the word of requester k was consumed.
- gnt_o  out  NREQ  registered one-hot grant.
- busy_o  out  1  high in GRANT.
- ser_dat_o  out  32  word to the serializer.
- ser_len_o  out  5  length to the serializer.
- ser_vld_o  out  1  ser_dat_o/ser_len_o carry a real requester word.
- ser_ack_i  in  1  one-cycle pulse from the serializer; the presented word was latched.

Behaviour:
- Reset values (asynchronous): state=IDLE, gnt_o=0, rr pointer=0, burst count=0. Outputs: ack_o=0, busy_o=0, ser_vld_o=0, ser_dat_o=IDLE_DAT, ser_len_o=IDLE_LEN.
- Reset asserted mid-grant: grant dropped at once, no ack issued. After release, arbitration restarts from pointer 0.
- States: IDLE, GRANT, REL.
- IDLE -> GRANT when |req_i.
  - Winner = first k with req_i[k]=1, searching from pointer upward with wrap NREQ-1 -> 0.
  - On that edge: gnt_o <= onehot(winner), pointer <= (winner+1) mod NREQ, burst count <= 0.
  - Latency req_i to gnt_o: 1 cycle.
- GRANT, ser_ack_i=1:
  - ack_o[sel] = 1 in the same cycle; combinational from registered gnt_o, no other ack_o bits high.
  - If burst count == BURST-1 -> REL; else burst count increments and the block stays in GRANT.
- GRANT, ser_ack_i=0 and req_i[sel]=0: -> REL; the requester withdrew.
- GRANT, simultaneous ser_ack_i and req_i[sel] drop: ack is delivered, then the burst rule applies; the next cycle sees the drop and goes to REL.
- REL: gnt_o <= 0, one cycle, then -> IDLE. Gives a guaranteed rearbitration point and a mux switch gap.
- Data mux:
  - In GRANT: ser_dat_o = rnd_i slice sel, ser_len_o = rnd_len_i slice sel, ser_vld_o = req_i[sel].
  - Otherwise: IDLE_DAT, IDLE_LEN, ser_vld_o=0.
- ser_ack_i in IDLE or REL: ignored, ack_o stays 0. Counts as a serializer underrun; no state change.
- Requester contract:
  - Word k must stay stable from req_i[k] rising until the cycle of ack_o[k].
  - The next word may be presented on the cycle after ack_o[k].
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1, BURST words each.

Optional Feature:
- Macro: PNSER_ARB_FIXPRI_EN.
- Defined: requester 0 wins the IDLE arbitration whenever req_i[0]=1, regardless of the pointer. Its grants do not advance the pointer. Other requesters remain round-robin among themselves.
- Undefined: pure round-robin as above; requester 0 has no special treatment.

Test Plan:
- Reset with req_i=4'b1111 held, release -> 1 cycle later gnt_o=4'b0001, ser_dat_o=rnd_i[31:0], ack_o=0 until the first ser_ack_i.
- All four requesting, BURST=4, ser_ack_i pulsed every 8 cycles -> ack_o[0] x4, REL, gnt_o=4'b0010 with ack_o[1] x4, then 2, 3, and back to 0.
- Requester 2 alone, drops req_i[2] 3 cycles after its first ack -> REL then IDLE; ser_vld_o=0, ser_dat_o=IDLE_DAT, ser_len_o=IDLE_LEN.
- ser_ack_i pulsed in IDLE -> ack_o stays 4'b0000, state stays IDLE.
- rst_i driven low mid-GRANT, 2 words into a burst -> gnt_o=0 and busy_o=0 immediately, with no clock edge needed. After release with req_i=4'b0110: gnt_o=4'b0010.
- With PNSER_ARB_FIXPRI_EN, req_i=4'b1011 held continuously -> gnt_o alternates 0001 (pointer unchanged), 0001, ... Without the macro -> 0001, 0010, 1000, 0001.
